multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the RV32I datapath subset: lw, sw, R-type ALU ops, I-type ALU ops, beq, bne and blt.
- Holds the instruction phase in a state register and drives the datapath muxes and write enables one phase per cycle.
- Talks to a single shared instruction/data memory through a req/ready handshake.
- Sits between the instruction register and the shared datapath (register file, ALU, ALUOut and data registers, PC).

---
 rtl/rv_ctrl_pkg.sv | 61 ++++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_control_fsm.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: state names,
// opcodes and the datapath mux / ALU operation codes.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    // Which rule the ALU decoder applies in the current phase.
    typedef enum logic [1:0] {
        ALU_CLS_ADD = 2'd0,
        ALU_CLS_SUB = 2'd1,
        ALU_CLS_R   = 2'd2,
        ALU_CLS_I   = 2'd3
    } alu_cls_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // funct3 010/011 (slt/sltu) are not supported on the ALU opcodes.
    function automatic logic is_bad_alu_f3(logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from the phase class, funct3 and Instr[30].
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [2:0] funct3,
    input  logic       instr30,
    output logic [2:0] alu_control
);

    // funct3 doubles as the ALU code for the non-add operations; only R-type
    // add with Instr[30] set becomes a subtract.
    always_comb begin
        alu_control = ALU_ADD;
        case (cls)
            ALU_CLS_SUB: alu_control = ALU_SUB;
            ALU_CLS_R: begin
                if (funct3 == 3'b000)
                    alu_control = instr30 ? ALU_SUB : ALU_ADD;
                else if (!is_bad_alu_f3(funct3))
                    alu_control = funct3;
            end
            ALU_CLS_I: begin
                if (funct3 != 3'b000 && !is_bad_alu_f3(funct3))
                    alu_control = funct3;
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for an RV32I subset (lw, sw, R/I ALU ops,
// beq/bne/blt) sharing one memory through a req/ready handshake.
// Handshake: mem_req is held with Adr_Src/Mem_Write stable until the cycle
// mem_ready is seen high; that cycle completes the request.
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr,
    input  logic        ZERO_flag,
    input  logic        sign_flag,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        Mem_Write,
    output logic        Adr_Src,
    output logic        IR_Write,
    output logic        PC_Write,
    output logic        Reg_Write,
    output logic [1:0]  ALU_SrcA,
    output logic [1:0]  ALU_SrcB,
    output logic [2:0]  ALU_CONTROL,
    output logic [1:0]  Imm_Src,
    output logic [1:0]  Result_Src,
    output logic        retire,
    output logic        trap,
    output logic [3:0]  state_dbg
);

    state_t          state, state_next;
    logic [TO_W-1:0] cnt, cnt_next;
    alu_cls_t        alu_cls;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            timeout_hit;
    logic            taken;
    logic            unused_instr;

    assign opcode       = Instr[6:0];
    assign funct3       = Instr[14:12];
    assign timeout_hit  = (cnt == TO_W'(MEM_TIMEOUT - 1));
    assign state_dbg    = state;
    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    alu_decoder u_alu_decoder (
        .cls         (alu_cls),
        .funct3      (funct3),
        .instr30     (Instr[30]),
        .alu_control (ALU_CONTROL)
    );

    // Phase register and memory-wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Branch condition from the compare subtraction flags.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = ZERO_flag;
            F3_BNE:  taken = ~ZERO_flag;
            F3_BLT:  taken = sign_flag;
            default: taken = 1'b0;
        endcase
    end

    // Next phase and per-phase datapath controls; everything stays 0 in reset.
    // The counter clears whenever the phase changes and only counts while a
    // memory phase waits; ready on the last allowed cycle still completes.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        alu_cls    = ALU_CLS_ADD;
        mem_req    = 1'b0;
        Mem_Write  = 1'b0;
        Adr_Src    = 1'b0;
        IR_Write   = 1'b0;
        PC_Write   = 1'b0;
        Reg_Write  = 1'b0;
        ALU_SrcA   = SRCA_PC;
        ALU_SrcB   = SRCB_RS2;
        Imm_Src    = IMM_I;
        Result_Src = RES_ALUOUT;
        retire     = 1'b0;
        trap       = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IR_Write   = 1'b1;
                        PC_Write   = 1'b1;
                        ALU_SrcA   = SRCA_PC;
                        ALU_SrcB   = SRCB_FOUR;
                        Result_Src = RES_ALU;
                        state_next = S_DECODE;
                    end else if (timeout_hit) begin
                        state_next = S_TRAP;
                    end else begin
                        cnt_next = cnt + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    ALU_SrcA = SRCA_OLDPC;
                    ALU_SrcB = SRCB_IMM;
                    Imm_Src  = IMM_B;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_RTYPE:  state_next = is_bad_alu_f3(funct3) ? S_TRAP : S_EXECUTER;
                        OP_ITYPE:  state_next = is_bad_alu_f3(funct3) ? S_TRAP : S_EXECUTEI;
                        OP_BRANCH: state_next = (funct3 == F3_BEQ || funct3 == F3_BNE ||
                                                 funct3 == F3_BLT) ? S_BRANCH : S_TRAP;
                        default:   state_next = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    ALU_SrcA   = SRCA_RS1;
                    ALU_SrcB   = SRCB_IMM;
                    Imm_Src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    Adr_Src = 1'b1;
                    if (mem_ready)        state_next = S_MEMWB;
                    else if (timeout_hit) state_next = S_TRAP;
                    else                  cnt_next   = cnt + TO_W'(1);
                end
                S_MEMWB: begin
                    Result_Src = RES_DATA;
                    Reg_Write  = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    Mem_Write = 1'b1;
                    Adr_Src   = 1'b1;
                    if (mem_ready) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else if (timeout_hit) begin
                        state_next = S_TRAP;
                    end else begin
                        cnt_next = cnt + TO_W'(1);
                    end
                end
                S_EXECUTER: begin
                    ALU_SrcA   = SRCA_RS1;
                    ALU_SrcB   = SRCB_RS2;
                    alu_cls    = ALU_CLS_R;
                    state_next = S_ALUWB;
                end
                S_EXECUTEI: begin
                    ALU_SrcA   = SRCA_RS1;
                    ALU_SrcB   = SRCB_IMM;
                    Imm_Src    = IMM_I;
                    alu_cls    = ALU_CLS_I;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    Result_Src = RES_ALUOUT;
                    Reg_Write  = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    ALU_SrcA   = SRCA_RS1;
                    ALU_SrcB   = SRCB_RS2;
                    alu_cls    = ALU_CLS_SUB;
                    Result_Src = RES_ALUOUT;
                    PC_Write   = taken;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    state_next = S_TRAP;
                end
                default: state_next = S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected output trace
// built from the instruction class rules, compared cycle by cycle.
module tb_multicycle_control_fsm;

    localparam int MEM_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr;
    logic        ZERO_flag, sign_flag, mem_ready;
    logic        mem_req, Mem_Write, Adr_Src, IR_Write, PC_Write, Reg_Write;
    logic [1:0]  ALU_SrcA, ALU_SrcB, Imm_Src, Result_Src;
    logic [2:0]  ALU_CONTROL;
    logic        retire, trap;
    logic [3:0]  state_dbg;
    logic [18:0] obs;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .Instr(Instr), .ZERO_flag(ZERO_flag),
        .sign_flag(sign_flag), .mem_ready(mem_ready), .mem_req(mem_req),
        .Mem_Write(Mem_Write), .Adr_Src(Adr_Src), .IR_Write(IR_Write),
        .PC_Write(PC_Write), .Reg_Write(Reg_Write), .ALU_SrcA(ALU_SrcA),
        .ALU_SrcB(ALU_SrcB), .ALU_CONTROL(ALU_CONTROL), .Imm_Src(Imm_Src),
        .Result_Src(Result_Src), .retire(retire), .trap(trap),
        .state_dbg(state_dbg)
    );

    assign obs = {mem_req, Mem_Write, Adr_Src, IR_Write, PC_Write, Reg_Write,
                  ALU_SrcA, ALU_SrcB, ALU_CONTROL, Imm_Src, Result_Src, retire, trap};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [18:0] exp_q[$];
    bit          rdy_q[$];
    string       tag_q[$];
    logic [31:0] cur_instr;
    int          instr_no = 0;

    task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] mk(bit req, bit wr, bit adr, bit irw, bit pcw, bit rw,
                                       logic [1:0] sa, logic [1:0] sb, logic [2:0] alu,
                                       logic [1:0] imm, logic [1:0] res, bit ret, bit trp);
        return {req, wr, adr, irw, pcw, rw, sa, sb, alu, imm, res, ret, trp};
    endfunction

    task automatic push(input bit r, input logic [18:0] e, input string t);
        rdy_q.push_back(r);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic push_trap(output bit tr);
        for (int i = 0; i < 3; i++)
            push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0,0,1), "trap");
        tr = 1'b1;
    endtask

    // A memory phase with w not-ready cycles: ready on cycle w+1, or a trap
    // once MEM_TIMEOUT cycles have passed without ready.
    task automatic add_wait(input int w, input logic [18:0] wv, input logic [18:0] dv,
                            input string nm, output bit tr);
        int n;
        n = (w < MEM_TIMEOUT) ? w : MEM_TIMEOUT;
        for (int i = 0; i < n; i++) push(1'b0, wv, {nm, "_wait"});
        if (w >= MEM_TIMEOUT) push_trap(tr);
        else begin
            push(1'b1, dv, nm);
            tr = 1'b0;
        end
    endtask

    task automatic build(input logic [31:0] ins, input int fw, input int mw,
                         input bit z, input bit s, output bit tr);
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] alu;
        bit         tk;
        op = ins[6:0];
        f3 = ins[14:12];
        exp_q.delete(); rdy_q.delete(); tag_q.delete();
        add_wait(fw, mk(1,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0,0,0),
                 mk(1,0,0,1,1,0,2'd0,2'd2,3'd0,2'd0,2'd2,0,0), "fetch", tr);
        if (tr) return;
        push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,2'd1,2'd1,3'd0,2'd2,2'd0,0,0), "decode");
        if (op == 7'b0000011) begin
            push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,2'd2,2'd1,3'd0,2'd0,2'd0,0,0), "memadr");
            add_wait(mw, mk(1,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0,0,0),
                     mk(1,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0,0,0), "memread", tr);
            if (!tr)
                push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd0,2'd1,1,0), "memwb");
        end else if (op == 7'b0100011) begin
            push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,2'd2,2'd1,3'd0,2'd1,2'd0,0,0), "memadr");
            add_wait(mw, mk(1,1,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0,0,0),
                     mk(1,1,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0,1,0), "memwrite", tr);
        end else if ((op == 7'b0110011 || op == 7'b0010011) && f3 != 3'd2 && f3 != 3'd3) begin
            alu = f3;
            if (op == 7'b0110011 && f3 == 3'd0 && ins[30]) alu = 3'b010;
            if (op == 7'b0110011)
                push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,2'd2,2'd0,alu,2'd0,2'd0,0,0), "execr");
            else
                push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,2'd2,2'd1,alu,2'd0,2'd0,0,0), "execi");
            push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd0,2'd0,1,0), "aluwb");
        end else if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4)) begin
            tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : s;
            push(1'($urandom_range(0, 1)), mk(0,0,0,0,tk,0,2'd2,2'd0,3'b010,2'd0,2'd0,1,0), "branch");
        end else begin
            push_trap(tr);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_seq(input int limit);
        for (int i = 0; i < limit && i < exp_q.size(); i++) begin
            mem_ready = rdy_q[i];
            Instr     = cur_instr;
            @(negedge clk);
            check_eq($sformatf("i%0d_%s_c%0d", instr_no, tag_q[i], i + 1), obs, exp_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("rst_async", obs, 19'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_hold", obs, 19'd0);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] ins, input int fw, input int mw,
                           input bit z, input bit s);
        bit tr;
        cur_instr = ins;
        ZERO_flag = z;
        sign_flag = s;
        build(ins, fw, mw, z, s, tr);
        run_seq(exp_q.size());
        instr_no++;
        if (tr) do_reset();
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 15) == 0) return $urandom_range(16, 17);
        return $urandom_range(0, 3);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          tr;
        logic [31:0] ins;
        logic [6:0]  op;
        int          kind;
        rst_n = 1'b0; mem_ready = 1'b0; Instr = 32'd0; ZERO_flag = 1'b0; sign_flag = 1'b0;
        cur_instr = 32'd0;
        @(posedge clk);
        #1;
        do_reset();

        run_one(32'h002081B3, 0, 0, 0, 0);   // add
        run_one(32'h402081B3, 0, 0, 0, 0);   // sub
        run_one(32'h40008093, 0, 0, 0, 0);   // addi with bit30 set
        run_one(32'h0020A183, 0, 3, 0, 0);   // lw, 3 wait cycles
        run_one(32'h0020A023, 1, 2, 0, 0);   // sw
        run_one(32'h00208063, 0, 0, 1, 0);   // beq taken
        run_one(32'h00208063, 0, 0, 0, 1);   // beq not taken
        run_one(32'h0020C063, 0, 0, 0, 1);   // blt taken
        run_one(32'h0020C063, 0, 0, 1, 0);   // blt not taken
        run_one(32'h00209063, 0, 0, 0, 0);   // bne taken
        run_one(32'h002081B3, 16, 0, 0, 0);  // fetch timeout
        run_one(32'h002081B3, 15, 0, 0, 0);  // ready on the last allowed cycle
        run_one(32'h0020A183, 0, 16, 0, 0);  // load timeout
        run_one(32'h0020A023, 0, 15, 0, 0);  // store, ready on last cycle
        run_one(32'h0000007F, 0, 0, 0, 0);   // illegal opcode
        run_one(32'h0020A1B3, 0, 0, 0, 0);   // R-type funct3 010
        run_one(32'h0020E063, 0, 0, 0, 0);   // branch funct3 110

        // Abandon a store mid-request with an asynchronous reset.
        cur_instr = 32'h0020A023;
        build(cur_instr, 0, 5, 0, 0, tr);
        run_seq(4);
        mem_ready = 1'b0;
        #1;
        check_eq("pre_rst_memwrite", obs, mk(1,1,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0,0,0));
        do_reset();
        run_one(32'h002081B3, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            ins  = $urandom;
            kind = $urandom_range(0, 9);
            case (kind)
                0:       op = 7'b0000011;
                1:       op = 7'b0100011;
                2, 3:    op = 7'b0110011;
                4, 5, 9: op = 7'b0010011;
                6, 7:    op = 7'b1100011;
                default: op = 7'($urandom);
            endcase
            ins[6:0] = op;
            run_one(ins, rand_wait(), rand_wait(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
